fifo_regs_prog_th: RTL and testbench
====================================

// Module: fifo_regs_prog_th
// PURPOSE
// - Register-based synchronous FIFO, successor of the fixed-threshold register FIFO.
// - Adds runtime-programmable almost-full/almost-empty thresholds, a synchronous flush,
//   and sticky overflow/underflow error flags; supports FWFT or standard read mode.
// - Intended for shallow (2..16 entry) buffering between streaming stages in one clock domain.
// PARAMETERS
// - DW        32  data width in bits (>=1)
// - DEPTH     4   number of entries, 2..16 (any integer, need not be a power of 2)
// - FWFT_MODE 1   1: first-word-fall-through (read latency 0); 0: standard (read latency 1)
// - CW        $clog2(DEPTH+1)  count/threshold width (localparam, derived, not overridable)
// PORTS
// - clk         in   1   clock, all logic on rising edge
// - rst_n       in   1   reset, asynchronous, active-low
// - wen         in   1   write request
// - din         in   DW  write data
// - ren         in   1   read request
// - dout        out  DW  read data
// - full        out  1   data_cnt == DEPTH
// - empty       out  1   data_cnt == 0
// - almost_full out  1   data_cnt >= af_th
// - almost_empty out 1   data_cnt <= ae_th
// - af_th       in   CW  almost-full threshold, runtime, quasi-static
// - ae_th       in   CW  almost-empty threshold, runtime, quasi-static
// - flush       in   1   synchronous clear of contents
// - overflow    out  1   sticky: write attempted while full
// - underflow   out  1   sticky: read attempted while empty
// - err_clr     in   1   clears overflow/underflow
// - data_cnt    out  CW  current occupancy, 0..DEPTH
// - peak_cnt    out  CW  high-water mark (see CONFIGURATION)
// BEHAVIOUR
// - Reset: pointers=0, data_cnt=0, full=0, empty=1, overflow=0, underflow=0, peak_cnt=0.
// - Reset: dout=0 when FWFT_MODE=0.
// - Write accepted = wen & ~full & ~flush: din -> mem[wptr]; wptr wraps DEPTH-1 -> 0.
// - Read accepted  = ren & ~empty & ~flush: rptr wraps DEPTH-1 -> 0.
// - full/empty are registered, so a read on the same edge does not unblock a write at full.
//   Same at empty: a write on the same edge does not make a read acceptable.
// - data_cnt: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
// - full and empty are registered, updated from next count; valid the cycle after the edge.
// - almost_full/almost_empty: combinational compare of registered data_cnt vs the current
//   threshold inputs.
//   - af_th=0 gives almost_full=1 always; ae_th>=DEPTH gives almost_empty=1 always.
//   - At reset: almost_empty=1, almost_full=(af_th==0).
// - FWFT_MODE=1: dout = mem[rptr] combinationally; valid whenever empty=0; stale when empty.
// - FWFT_MODE=0: dout registered; loads mem[rptr] on the edge of an accepted read (1-cycle
//   latency); holds its value otherwise.
// - flush has highest priority: on the next edge rptr=wptr=0, data_cnt=0, empty=1, full=0.
//   A write or read in the flush cycle is dropped. Memory contents and dout are not cleared.
// - overflow set on wen & full & ~flush; underflow set on ren & empty & ~flush.
//   err_clr clears both; set wins over err_clr in the same cycle; flush does not clear them.
// - Reset asserted mid-operation: immediate return to reset values; in-flight data lost.
// CONFIGURATION
// - Macro FIFO_REGS_PEAK_EN.
//   - Defined: peak_cnt <= max(peak_cnt, next data_cnt) each edge; cleared to 0 by flush,
//     err_clr and reset.
//   - Not defined: peak_cnt tied to 0 and no tracking logic is built.
// TESTING
// - DEPTH=4, FWFT=1: write A1,A2,A3,A4 -> full=1, data_cnt=4; dout=A1 with no read issued.
// - At full, wen with FF -> overflow=1, data_cnt=4; 4 reads return A1..A4, FF never appears.
// - Concurrent wen/ren at data_cnt=2 for 10 cycles -> data_cnt stays 2, in-order data,
//   both pointers wrap.
// - af_th=3, ae_th=1, data_cnt=2: almost_full=0, almost_empty=0; set af_th=2 ->
//   almost_full=1 in the same cycle.
// - data_cnt=3, flush with wen (din=55) -> next cycle data_cnt=0, empty=1; 55 is not stored.
//   With FIFO_REGS_PEAK_EN, peak_cnt=0.
// - FWFT=0: write 11, read -> dout=11 one cycle after the read edge; ren at empty ->
//   underflow=1, dout stays 11; err_clr -> underflow=0.

Source files
------------

// File: rtl/fifo_regs_prog_th.sv
// Register FIFO with programmable almost-full/empty thresholds, flush and sticky errors; FWFT (0-cycle) or registered (1-cycle) read.
// Writes are dropped at full and reads at empty; optional high-water mark is built under FIFO_REGS_PEAK_EN.
module fifo_regs_prog_th #(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 4,
  parameter  int FWFT_MODE = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [DW-1:0] din,
  input  logic          ren,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  input  logic [CW-1:0] af_th,
  input  logic [CW-1:0] ae_th,
  input  logic          flush,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr,
  output logic [CW-1:0] data_cnt,
  output logic [CW-1:0] peak_cnt
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Acceptance uses the registered flags, so same-edge read/write never unblock each other.
  assign wr_acc = wen & ~full_q & ~flush;
  assign rd_acc = ren & ~empty_q & ~flush;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_acc) begin
        mem_d[wptr_q] = din;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (rd_acc) begin
        rptr_d = ptr_inc(rptr_q);
      end
      if (wr_acc && !rd_acc) begin
        cnt_d = cnt_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // Error flags: a new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q & ~err_clr;
    udf_d = udf_q & ~err_clr;
    if (wen && full_q && !flush) begin
      ovf_d = 1'b1;
    end
    if (ren && empty_q && !flush) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset; contents are qualified by empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  generate
    if (FWFT_MODE != 0) begin : g_fwft
      assign dout = mem_q[rptr_q];
    end else begin : g_std
      logic [DW-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) begin
          dout_d = mem_q[rptr_q];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign dout = dout_q;
    end
  endgenerate

`ifdef FIFO_REGS_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (flush || err_clr) begin
      peak_d = '0;
    end else if (cnt_d > peak_q) begin
      peak_d = cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_cnt = peak_q;
`else
  assign peak_cnt = '0;
`endif

  assign data_cnt     = cnt_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign almost_full  = (cnt_q >= af_th);
  assign almost_empty = (cnt_q <= ae_th);

endmodule

// File: tb/tb_fifo_regs_prog_th.sv
// Bench for fifo_regs_prog_th: FWFT and registered-read instances share stimulus and one queue model.
module tb_fifo_regs_prog_th;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen, ren, flush, err_clr;
  logic [DW-1:0] din;
  logic [CW-1:0] af_th, ae_th;

  logic [DW-1:0] dout, dout0;
  logic          full, empty, afull, aempty, ovf, udf;
  logic          full0, empty0, afull0, aempty0, ovf0, udf0;
  logic [CW-1:0] cnt, peak, cnt0, peak0;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout0;
  int            m_peak;

  always #5 clk = ~clk;

  fifo_regs_prog_th #(.DW(DW), .DEPTH(DEPTH), .FWFT_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren), .dout(dout),
    .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
    .af_th(af_th), .ae_th(ae_th), .flush(flush), .overflow(ovf), .underflow(udf),
    .err_clr(err_clr), .data_cnt(cnt), .peak_cnt(peak)
  );

  fifo_regs_prog_th #(.DW(DW), .DEPTH(DEPTH), .FWFT_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
    .af_th(af_th), .ae_th(ae_th), .flush(flush), .overflow(ovf0), .underflow(udf0),
    .err_clr(err_clr), .data_cnt(cnt0), .peak_cnt(peak0)
  );

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_dout0 = '0;
    m_peak  = 0;
  endtask

  // Applies one clock edge of the FIFO rules to the model, using pre-edge inputs.
  task automatic model_edge();
    int  n;
    bit  wa, ra;
    n  = mq.size();
    wa = wen && (n != DEPTH) && !flush;
    ra = ren && (n != 0) && !flush;
    m_ovf = (m_ovf && !err_clr) || (wen && n == DEPTH && !flush);
    m_udf = (m_udf && !err_clr) || (ren && n == 0 && !flush);
    if (flush) begin
      mq.delete();
    end else begin
      if (ra) m_dout0 = mq.pop_front();
      if (wa) mq.push_back(din);
    end
`ifdef FIFO_REGS_PEAK_EN
    if (flush || err_clr) m_peak = 0;
    else if (mq.size() > m_peak) m_peak = mq.size();
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle();
    wen = 0; ren = 0; flush = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; af_th = 3; ae_th = 1; din = '0;
    tick(); tick();
    #1;
    checks++; if (cnt !== 0)     begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (full !== 0)    begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (empty !== 1)   begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (aempty !== 1)  begin errors++; $display("FAIL reset_aempty got=%b exp=1", aempty); end
    checks++; if (afull !== 0)   begin errors++; $display("FAIL reset_afull got=%b exp=0", afull); end
    checks++; if (ovf !== 0 || udf !== 0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", ovf, udf); end
    checks++; if (peak !== 0)    begin errors++; $display("FAIL reset_peak got=%0d exp=0", peak); end
    checks++; if (dout0 !== 0)   begin errors++; $display("FAIL reset_dout0 got=%h exp=0", dout0); end
    af_th = 0;
    #1;
    checks++; if (afull !== 1)   begin errors++; $display("FAIL reset_afull_th0 got=%b exp=1", afull); end
    af_th = 3;
    rst_n = 1;
    tick();
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] exp;
    idle();
    for (int i = 1; i <= 4; i++) begin
      wen = 1; din = 32'hA0 + i;
      tick();
    end
    wen = 0;
    #1;
    checks++; if (full !== 1 || cnt !== 4) begin errors++; $display("FAIL fill_full got=%b/%0d exp=1/4", full, cnt); end
    checks++; if (dout !== 32'hA1) begin errors++; $display("FAIL fill_fwft_dout got=%h exp=a1", dout); end
    wen = 1; din = 32'hFF;
    tick();
    wen = 0;
    #1;
    checks++; if (ovf !== 1 || cnt !== 4) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/4", ovf, cnt); end
    for (int i = 1; i <= 4; i++) begin
      exp = 32'hA0 + i;
      ren = 1;
      #1;
      checks++; if (dout !== exp) begin errors++; $display("FAIL drain_dout got=%h exp=%h", dout, exp); end
      tick();
      checks++; if (dout0 !== exp) begin errors++; $display("FAIL drain_dout0 got=%h exp=%h", dout0, exp); end
    end
    ren = 0;
    #1;
    checks++; if (empty !== 1 || udf !== 0) begin errors++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty, udf); end
  endtask

  task automatic test_back_to_back();
    idle();
    err_clr = 1; tick(); err_clr = 0;
    checks++; if (ovf !== 0) begin errors++; $display("FAIL errclr_ovf got=%b exp=0", ovf); end
    for (int i = 0; i < 2; i++) begin
      wen = 1; din = 32'hB0 + i; tick();
    end
    for (int i = 0; i < 10; i++) begin
      wen = 1; ren = 1; din = 32'hC0 + i;
      #1;
      checks++; if (dout !== mq[0]) begin errors++; $display("FAIL b2b_dout got=%h exp=%h", dout, mq[0]); end
      tick();
      checks++; if (cnt !== 2) begin errors++; $display("FAIL b2b_cnt got=%0d exp=2", cnt); end
      checks++; if (dout0 !== m_dout0) begin errors++; $display("FAIL b2b_dout0 got=%h exp=%h", dout0, m_dout0); end
    end
    idle();
  endtask

  task automatic test_thresholds();
    idle();
    af_th = 3; ae_th = 1;
    #1;
    checks++; if (afull !== 0 || aempty !== 0) begin errors++; $display("FAIL th_cnt2 got=%b%b exp=00", afull, aempty); end
    af_th = 2;
    #1;
    checks++; if (afull !== 1) begin errors++; $display("FAIL th_af2 got=%b exp=1", afull); end
    ae_th = 5;
    #1;
    checks++; if (aempty !== 1) begin errors++; $display("FAIL th_ae_big got=%b exp=1", aempty); end
    af_th = 3; ae_th = 1;
  endtask

  task automatic test_flush();
    idle();
    wen = 1; din = 32'h33; tick();
    checks++; if (cnt !== 3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", cnt); end
    flush = 1; wen = 1; din = 32'h55; tick();
    idle();
    checks++; if (cnt !== 0 || empty !== 1 || full !== 0) begin errors++; $display("FAIL flush_state got=%0d/%b exp=0/1", cnt, empty); end
    checks++; if (peak !== 0) begin errors++; $display("FAIL flush_peak got=%0d exp=0", peak); end
    wen = 1; din = 32'h77; tick(); idle();
    checks++; if (cnt !== 1 || dout !== 32'h77) begin errors++; $display("FAIL flush_after got=%0d/%h exp=1/77", cnt, dout); end
    flush = 1; tick(); idle();
  endtask

  task automatic test_std_read();
    idle();
    wen = 1; din = 32'h11; tick();
    wen = 0; ren = 1; tick();
    checks++; if (dout0 !== 32'h11) begin errors++; $display("FAIL std_dout got=%h exp=11", dout0); end
    tick();
    ren = 0;
    checks++; if (udf0 !== 1 || dout0 !== 32'h11) begin errors++; $display("FAIL std_underflow got=%b/%h exp=1/11", udf0, dout0); end
    err_clr = 1; tick(); err_clr = 0;
    checks++; if (udf0 !== 0) begin errors++; $display("FAIL std_errclr got=%b exp=0", udf0); end
  endtask

  task automatic test_random();
    int n;
    idle();
    for (int c = 0; c < 400; c++) begin
      wen     = ($urandom_range(0, 1) == 1);
      ren     = ($urandom_range(0, 1) == 1);
      din     = $urandom;
      flush   = ($urandom_range(0, 31) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) af_th = CW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) ae_th = CW'($urandom_range(0, 7));
      #1;
      n = mq.size();
      checks++; if (cnt !== CW'(n) || cnt0 !== CW'(n)) begin errors++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d", cnt, cnt0, n); end
      checks++; if (full !== (n == DEPTH) || empty !== (n == 0)) begin errors++; $display("FAIL rnd_flags got=%b%b n=%0d", full, empty, n); end
      checks++; if (afull !== (n >= af_th) || aempty !== (n <= ae_th)) begin errors++; $display("FAIL rnd_almost got=%b%b n=%0d af=%0d ae=%0d", afull, aempty, n, af_th, ae_th); end
      checks++; if (ovf !== m_ovf || udf !== m_udf || ovf0 !== m_ovf || udf0 !== m_udf) begin errors++; $display("FAIL rnd_err got=%b%b exp=%b%b", ovf, udf, m_ovf, m_udf); end
      checks++; if (peak !== CW'(m_peak)) begin errors++; $display("FAIL rnd_peak got=%0d exp=%0d", peak, m_peak); end
      checks++; if (dout0 !== m_dout0) begin errors++; $display("FAIL rnd_dout0 got=%h exp=%h", dout0, m_dout0); end
      if (n != 0) begin
        checks++; if (dout !== mq[0]) begin errors++; $display("FAIL rnd_dout got=%h exp=%h", dout, mq[0]); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      wen = 1; din = $urandom; tick();
    end
    wen = 1; ren = 1;
    rst_n = 0;
    #1;
    checks++; if (cnt !== 0 || empty !== 1 || ovf !== 0 || udf !== 0) begin errors++; $display("FAIL midreset got=%0d/%b exp=0/1", cnt, empty); end
    checks++; if (dout0 !== 0 || peak !== 0) begin errors++; $display("FAIL midreset_dout0 got=%h/%0d exp=0/0", dout0, peak); end
    tick();
    idle();
    rst_n = 1;
    tick();
    checks++; if (cnt !== 0) begin errors++; $display("FAIL postreset_cnt got=%0d exp=0", cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_overflow();
    test_back_to_back();
    test_thresholds();
    test_flush();
    test_std_read();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
